// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall polarity,
// load opcodes, FSM state encoding and the EX->MEM bus layout.
package mem_stage_pkg;

  localparam int StallBus     = 6;
  localparam int StallMemBit  = 3;
  localparam int StallWbBit   = 4;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;

  localparam logic [2:0] MEM_OP_LW  = 3'd0;
  localparam logic [2:0] MEM_OP_LB  = 3'd1;
  localparam logic [2:0] MEM_OP_LBU = 3'd2;
  localparam logic [2:0] MEM_OP_LH  = 3'd3;
  localparam logic [2:0] MEM_OP_LHU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HELD = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  mem_op;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_fwd_t;

  // A load reads SRAM without writing and routes the read result to the RF.
  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en & (b.data_ram_wen == 4'd0) & b.sel_rf_res;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the SRAM word
// and sign- or zero-extends it according to mem_op.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] aligned
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[addr];
  // addr[0] is irrelevant for halfwords; misaligned accesses never reach here.
  assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    aligned = rdata;
    case (mem_op)
      MEM_OP_LB:  aligned = {{24{sel_byte[7]}}, sel_byte};
      MEM_OP_LBU: aligned = {24'd0, sel_byte};
      MEM_OP_LH:  aligned = {{16{sel_half[15]}}, sel_half};
      MEM_OP_LHU: aligned = {16'd0, sel_half};
      default:    aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX result, waits for (and holds)
// the SRAM read response, and produces the write-back / bypass buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    stallreq_mem
);

  ex_to_mem_t bus_in;
  ex_to_mem_t bus_reg;
  mem_state_e state_reg;
  mem_state_e state_next;
  logic [31:0] hold_reg;
  logic [31:0] hold_next;
  logic [31:0] aligned_rdata;
  logic [31:0] load_data;
  logic        reg_load;
  logic        bubble;
  logic        cur_is_load;
  rf_fwd_t     fwd;
  logic        unused_stall_bits;

  assign bus_in   = ex_to_mem_bus;
  assign reg_load = (stall[StallMemBit] == NoStop);
  assign bubble   = (stall[StallMemBit] == Stop) && (stall[StallWbBit] == NoStop);
  assign unused_stall_bits = ^{stall[StallBus-1:StallWbBit+1], stall[StallMemBit-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_reg <= '0;
    end else if (bubble) begin
      bus_reg <= '0;
    end else if (reg_load) begin
      bus_reg <= bus_in;
    end
  end

  assign cur_is_load = is_load(bus_reg);

  // One aligner serves both the pass-through path and the hold capture.
  mem_load_align u_align (
    .mem_op  (bus_reg.mem_op),
    .addr    (bus_reg.ex_result[1:0]),
    .rdata   (data_sram_rdata),
    .aligned (aligned_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      hold_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    if (reg_load) begin
      state_next = is_load(bus_in) ? ST_WAIT : ST_IDLE;
    end else if (bubble) begin
      state_next = ST_IDLE;
    end else if (state_reg == ST_WAIT && data_sram_rvalid) begin
      // Response arrived while frozen: keep it until the stage advances.
      state_next = ST_HELD;
      hold_next  = aligned_rdata;
    end
  end

  assign load_data = (state_reg == ST_HELD) ? hold_reg : aligned_rdata;

  assign stallreq_mem = ~rst & cur_is_load & (state_reg == ST_WAIT) & ~data_sram_rvalid;

  always_comb begin
    fwd.rf_we    = bus_reg.rf_we;
    fwd.rf_waddr = bus_reg.rf_waddr;
    fwd.rf_wdata = bus_reg.sel_rf_res ? load_data : bus_reg.ex_result;
  end

  assign mem_to_wb_bus = {bus_reg.ex_pc, fwd};
  assign mem_to_id_bus = fwd;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits between the execute stage (producer of ex_to_mem_bus and data SRAM requests) and the write-back stage.
- Registers the EX result under the shared stall bus and waits for data SRAM read responses, holding them if the pipeline is frozen.
- Aligns and sign/zero-extends load data, selects the register-file write value, and forwards {rf_we, rf_waddr, rf_wdata} to decode for bypassing.

Parameters:
- None. Bus widths come from shared defines: StallBus=6, EX_TO_MEM_WD=79, MEM_TO_WB_WD=70, MEM_TO_ID_WD=38.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  StallBus  pipeline stall vector; bit3 = MEM, bit4 = WB; Stop=1
ex_to_mem_bus  in  79  {ex_pc[31:0], data_ram_en, data_ram_wen[3:0], mem_op[2:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}, MSB first
data_sram_rdata  in  32  SRAM read data, valid only in the cycle data_sram_rvalid=1
data_sram_rvalid  in  1  SRAM read response strobe
mem_to_wb_bus  out  70  {mem_pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}
mem_to_id_bus  out  38  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
stallreq_mem  out  1  request to stall controller: load outstanding

Behaviour:
- Pipeline register bus_r, with this priority:
  - rst → 0.
  - stall[3]=Stop & stall[4]=NoStop → 0 (bubble).
  - stall[3]=NoStop → ex_to_mem_bus.
  - Otherwise hold.
- "reg_load" means a new value is written from ex_to_mem_bus this edge.
- is_load = data_ram_en & (data_ram_wen==0) & sel_rf_res, taken from bus_r.
- mem_op encoding:
  - 0 LW
  - 1 LB
  - 2 LBU
  - 3 LH
  - 4 LHU
  - 5–7 are treated as LW.
- Alignment uses addr = ex_result[1:0]:
  - LB/LBU select byte rdata[8*addr+7 : 8*addr].
  - LH/LHU select rdata[31:16] if addr[1], else rdata[15:0]; addr[0] is ignored (misalignment is trapped upstream).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, WAIT, HELD. Encoding in the shared package. Transitions:
  - rst → IDLE (from any state, including mid-WAIT). hold_r is cleared to 0.
  - reg_load → WAIT if the incoming bus is a load, else IDLE. This has priority over the rules below.
  - WAIT & data_sram_rvalid & ~reg_load → HELD; hold_r ← aligned(data_sram_rdata).
  - HELD holds until reg_load or rst.
  - data_sram_rvalid in IDLE or HELD is ignored; there is no capture.
- load_data = (state==HELD) ? hold_r : aligned(data_sram_rdata).
- stallreq_mem = is_load & (state==WAIT) & ~data_sram_rvalid. This is combinational and 0 in reset.
- Response timing:
  - The earliest response arrives the first cycle the load sits in MEM; that is zero extra latency.
  - Each cycle rvalid is late adds one stall cycle.
  - If WAIT & rvalid occurs while stall[3]=NoStop, data passes straight to WB that cycle; HELD is not needed.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- mem_to_id_bus = {rf_we, rf_waddr, rf_wdata}, same cycle as mem_to_wb_bus.
- During WAIT without rvalid, rf_wdata is don't-care. The stall controller must freeze WB-side consumption; decode must not bypass while stallreq_mem=1.
- Outputs after reset: every bus field is 0, including rf_we=0. stallreq_mem=0.
- A bubble in MEM gives rf_we=0 and state IDLE.
- Stores: data_ram_wen≠0 is not a load; no wait; rf_we comes from the bus (normally 0).

Decomposition:
- Shared defines header: StallBus, Stop/NoStop, EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD, mem_op codes, FSM state codes.
- One combinational sub-module, mem_load_align: inputs mem_op, addr[1:0], rdata; output aligned data. Reused by hold_r capture and the direct path.

Test Plan:
1. Reset → mem_to_wb_bus=0, mem_to_id_bus=0, stallreq_mem=0. Assert rst mid-WAIT → next cycle IDLE, stallreq_mem=0.
2. ALU op: ex_result=0x1234_5678, rf_we=1, waddr=5, no stalls → next cycle mem_to_wb rf_wdata=0x12345678, waddr=5; same value on mem_to_id_bus.
3. Load alignment, rdata=0x80FF_7F01, rvalid=1 immediately, stallreq_mem stays 0:
   - LB addr=3 → 0xFFFFFF80
   - LBU addr=3 → 0x00000080
   - LB addr=1 → 0x0000007F
   - LH addr=2 → 0xFFFF80FF
   - LHU addr=0 → 0x00007F01
   - LW → 0x80FF7F01
4. LW with rvalid delayed 2 cycles → stallreq_mem=1 for exactly 2 cycles. With stall[3]=Stop during that window, bus_r holds. On the rvalid cycle with stall[3]=NoStop, rf_wdata=rdata.
5. LW with rvalid=1 while stall[3]=Stop & stall[4]=Stop for 3 cycles, and data_sram_rdata changed to garbage after → state HELD, rf_wdata keeps the captured word every cycle. After release, WB latches the captured word.
6. stall[3]=Stop, stall[4]=NoStop → next cycle mem_to_wb_bus=0 (bubble), state IDLE. A spurious rvalid in IDLE leaves outputs unchanged.
